cpu_wb_bridge: RTL and testbench

Downstream neighbour of the multi-cycle CPU top. Consumes its memory strobe, write enable, address and store data, and runs one classic Wishbone B3 single-read/write cycle per access. Drives the CPU's MIO_ready and the returned load data. One outstanding access at a time; no bursts or pipelining.

---
 rtl/cpu_bus_pkg.sv | 14 +
 rtl/cpu_wb_bridge.sv | 157 +++++++++++++++
 tb/tb_cpu_wb_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: constants shared by the CPU-to-Wishbone bridge.
//   - bridge state encoding (IDLE / BUS / DONE)
//   - SEL_ALL   : byte-select pattern for full-word accesses
//   - ERR_RDATA : load data returned when a cycle ends in error or timeout
package cpu_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0]  SEL_ALL   = 4'b1111;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/cpu_wb_bridge.sv
// cpu_wb_bridge: turns one CPU memory strobe into one classic Wishbone B3
// single read/write cycle and returns a one-cycle ready pulse to the CPU.
// One access is in flight at a time.
//
// Ports:
//   clk, reset            clock (rising edge) and async active-low reset
//   cpu_stb_i/we_i        access request and direction from the CPU
//   cpu_addr_i/dat_i      byte address and store data from the CPU
//   cpu_dat_o             load data (held until the next read completes)
//   cpu_ready_o           one-cycle completion pulse
//   wb_cyc_o/stb_o/we_o   Wishbone cycle, strobe, write enable
//   wb_adr_o/dat_o/sel_o  word-aligned address, write data, byte selects
//   wb_dat_i/ack_i/err_i  Wishbone read data, acknowledge, error
//   bus_err_o             sticky error flag, cleared only by reset
//
// Build option: define CPU_WB_TIMEOUT_EN to end a BUS phase that has seen
// no ack/err for TIMEOUT_CYC cycles, exactly as if wb_err_i had arrived.
module cpu_wb_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_stb_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic [DATA_W-1:0] cpu_dat_o,
  output logic              cpu_ready_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              bus_err_o
);

  logic [1:0]        state_r;
  logic              cyc_r;
  logic              we_r;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] wdat_r;
  logic [DATA_W-1:0] rdat_r;
  logic              ready_r;
  logic              bus_err_r;
  logic              tmo_s;
  logic              unused_s;

  // The two byte-offset address bits never reach the word-addressed bus.
  assign unused_s = ^cpu_addr_i[1:0];

`ifdef CPU_WB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt_r;

  // Count BUS cycles; the count restarts from zero every time BUS is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_BUS) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  // The count holds k-1 during the k-th BUS cycle, so compare against
  // TIMEOUT_CYC-1 to end the cycle after exactly TIMEOUT_CYC BUS cycles.
  assign tmo_s = (state_r == ST_BUS) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
`else
  localparam int TMO_CFG_UNUSED = TIMEOUT_CYC;

  assign tmo_s = 1'b0;
`endif

  // Bridge FSM: launch in IDLE, wait for ack/err in BUS, pulse ready in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cyc_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= {ADDR_W{1'b0}};
      wdat_r    <= {DATA_W{1'b0}};
      rdat_r    <= {DATA_W{1'b0}};
      ready_r   <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (cpu_stb_i) begin
            adr_r   <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
            we_r    <= cpu_we_i;
            wdat_r  <= cpu_dat_i;
            cyc_r   <= 1'b1;
            state_r <= ST_BUS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS: begin
          // err (or a timeout) takes priority over a simultaneous ack
          if (wb_err_i || tmo_s) begin
            cyc_r     <= 1'b0;
            ready_r   <= 1'b1;
            bus_err_r <= 1'b1;
            if (!we_r) begin
              rdat_r <= ERR_RDATA;
            end else begin
              rdat_r <= rdat_r;
            end
            state_r <= ST_DONE;
          end else if (wb_ack_i) begin
            cyc_r   <= 1'b0;
            ready_r <= 1'b1;
            if (!we_r) begin
              rdat_r <= wb_dat_i;
            end else begin
              rdat_r <= rdat_r;
            end
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_BUS;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o    = cyc_r;
  assign wb_stb_o    = cyc_r;
  assign wb_we_o     = we_r;
  assign wb_adr_o    = adr_r;
  assign wb_dat_o    = wdat_r;
  assign wb_sel_o    = SEL_ALL;
  assign cpu_dat_o   = rdat_r;
  assign cpu_ready_o = ready_r;
  assign bus_err_o   = bus_err_r;

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Self-checking bench for cpu_wb_bridge: directed Wishbone scenarios plus a
// randomized access stream checked against a transaction-level model
// (expected load data, sticky error, cycle and pulse counts).
module tb_cpu_wb_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_stb_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_dat_i;
  logic [DW-1:0] cpu_dat_o;
  logic          cpu_ready_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // transaction-level model state
  logic [DW-1:0] exp_rdat;
  logic          exp_err;
  int            exp_cycles;
  int            exp_readies;
  int            mon_cycles = 0;
  int            mon_readies = 0;
  logic          mon_cyc_q = 1'b0;
  logic          mon_rdy_q = 1'b0;

  cpu_wb_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ready_o(cpu_ready_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Count Wishbone cycle starts and ready pulses (pre-edge values).
  always @(posedge clk) begin
    if (wb_cyc_o && !mon_cyc_q) mon_cycles++;
    if (cpu_ready_o && !mon_rdy_q) mon_readies++;
    mon_cyc_q <= wb_cyc_o;
    mon_rdy_q <= cpu_ready_o;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One access. Called at a negedge; lead = cycles until BUS (1 from IDLE,
  // 2 when issued in the DONE cycle of the previous access). Returns at the
  // DONE negedge if hold_stb, else one cycle later (back in IDLE).
  task automatic access(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdat, input int waits,
                        input logic err, input logic ack_too,
                        input logic hold_stb, input int lead,
                        input logic [DW-1:0] rdat);
    logic [AW-1:0] exp_adr;
    exp_adr = {addr[AW-1:2], 2'b00};
    cpu_stb_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_dat_i  = wdat;
    for (int i = 1; i < lead; i++) begin
      step();
      check_eq("idle_before_bus_cyc", {63'd0, wb_cyc_o}, 64'd0);
      check_eq("idle_before_bus_rdy", {63'd0, cpu_ready_o}, 64'd0);
    end
    step();
    check_eq("bus_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd3);
    check_eq("bus_adr", {32'd0, wb_adr_o}, {32'd0, exp_adr});
    check_eq("bus_we", {63'd0, wb_we_o}, {63'd0, we});
    check_eq("bus_sel", {60'd0, wb_sel_o}, 64'hF);
    if (we) check_eq("bus_wdat", {32'd0, wb_dat_o}, {32'd0, wdat});
    if (!hold_stb) cpu_stb_i = 1'b0;
    cpu_addr_i = $urandom;
    cpu_dat_i  = $urandom;
    cpu_we_i   = ~we;
    for (int i = 0; i < waits; i++) begin
      wb_dat_i = $urandom;
      step();
      check_eq("wait_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd3);
      check_eq("wait_adr", {32'd0, wb_adr_o}, {32'd0, exp_adr});
      check_eq("wait_we", {63'd0, wb_we_o}, {63'd0, we});
      if (we) check_eq("wait_wdat", {32'd0, wb_dat_o}, {32'd0, wdat});
      check_eq("wait_rdy", {63'd0, cpu_ready_o}, 64'd0);
    end
    wb_ack_i = err ? ack_too : 1'b1;
    wb_err_i = err;
    wb_dat_i = rdat;
    step();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    exp_cycles++;
    exp_readies++;
    if (!we) exp_rdat = err ? 32'h0 : rdat;
    exp_err = exp_err | err;
    check_eq("done_rdy", {63'd0, cpu_ready_o}, 64'd1);
    check_eq("done_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    check_eq("done_rdat", {32'd0, cpu_dat_o}, {32'd0, exp_rdat});
    check_eq("done_err", {63'd0, bus_err_o}, {63'd0, exp_err});
    if (hold_stb) begin
      cpu_we_i = $urandom;
    end else begin
      step();
      check_eq("after_rdy", {63'd0, cpu_ready_o}, 64'd0);
      check_eq("after_cyc", {63'd0, wb_cyc_o}, 64'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_stb_i = 1'b0;
    exp_rdat = 32'h0;
    exp_err = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int  tmo_seen;
    int  rdy_cnt;
    int  prev_hold;
    logic hold;
    cpu_stb_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_dat_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    exp_cycles = 0; exp_readies = 0;
    do_reset();
    check_eq("rst_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    check_eq("rst_we", {63'd0, wb_we_o}, 64'd0);
    check_eq("rst_adr", {32'd0, wb_adr_o}, 64'd0);
    check_eq("rst_wdat", {32'd0, wb_dat_o}, 64'd0);
    check_eq("rst_sel", {60'd0, wb_sel_o}, 64'hF);
    check_eq("rst_rdat", {32'd0, cpu_dat_o}, 64'd0);
    check_eq("rst_rdy", {63'd0, cpu_ready_o}, 64'd0);
    check_eq("rst_err", {63'd0, bus_err_o}, 64'd0);
    reset = 1'b1;
    step();

    // directed: read with immediate ack, write with 4 waits, back-to-back pair
    access(1'b0, 32'h0000_1006, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001);
    access(1'b1, 32'h0000_2000, 32'h1234_5678, 4, 1'b0, 1'b0, 1'b0, 1, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_3008, 32'h0, 1, 1'b0, 1'b0, 1'b1, 1, 32'h0BAD_F00D);
    access(1'b1, 32'h0000_300C, 32'hCAFE_0002, 0, 1'b0, 1'b0, 1'b0, 2, 32'h1111_2222);
    step();
    check_eq("b2b_cycles", 64'(mon_cycles), 64'(exp_cycles));
    check_eq("b2b_readies", 64'(mon_readies), 64'(exp_readies));
    check_eq("no_err_yet", {63'd0, bus_err_o}, 64'd0);

    // error with simultaneous ack, then a good read keeps the sticky flag
    access(1'b0, 32'h0000_4000, 32'h0, 2, 1'b1, 1'b1, 1'b0, 1, 32'h7777_7777);
    access(1'b0, 32'h0000_4004, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1, 32'h5555_AAAA);

    // randomized stream, with stray ack/err in IDLE that must be ignored
    prev_hold = 0;
    for (int n = 0; n < 40; n++) begin
      hold = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 4),
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), hold,
             prev_hold ? 2 : 1, $urandom);
      prev_hold = hold ? 1 : 0;
      if (!hold && $urandom_range(0, 2) == 0) begin
        wb_ack_i = 1'b1;
        wb_err_i = 1'($urandom_range(0, 1));
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check_eq("stray_cyc", {62'd0, wb_cyc_o, cpu_ready_o}, 64'd0);
        check_eq("stray_err", {63'd0, bus_err_o}, {63'd0, exp_err});
        check_eq("stray_rdat", {32'd0, cpu_dat_o}, {32'd0, exp_rdat});
      end
    end
    repeat (2) step();
    check_eq("rand_cycles", 64'(mon_cycles), 64'(exp_cycles));
    check_eq("rand_readies", 64'(mon_readies), 64'(exp_readies));

    // reset asserted in the middle of a BUS phase
    cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_5000;
    step();
    cpu_stb_i = 1'b0;
    check_eq("pre_rst_cyc", {63'd0, wb_cyc_o}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_outs", {61'd0, wb_cyc_o, wb_stb_o, cpu_ready_o}, 64'd0);
    check_eq("midrst_err", {63'd0, bus_err_o}, 64'd0);
    check_eq("midrst_rdat", {32'd0, cpu_dat_o}, 64'd0);
    exp_rdat = 32'h0;
    exp_err = 1'b0;
    step();
    reset = 1'b1;
    step();
    access(1'b0, 32'h0000_6010, 32'h0, 1, 1'b0, 1'b0, 1'b0, 1, 32'h600D_0123);

    // an access that is never acknowledged
    cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_7000;
    tmo_seen = 0;
    rdy_cnt = 0;
`ifdef CPU_WB_TIMEOUT_EN
    for (int k = 1; k <= 40 && tmo_seen == 0; k++) begin
      step();
      cpu_stb_i = 1'b0;
      if (cpu_ready_o) tmo_seen = k;
    end
    check_eq("tmo_latency", 64'(tmo_seen), 64'(TMO + 1));
    check_eq("tmo_rdat", {32'd0, cpu_dat_o}, 64'd0);
    check_eq("tmo_err", {63'd0, bus_err_o}, 64'd1);
`else
    for (int k = 1; k <= 1000; k++) begin
      step();
      cpu_stb_i = 1'b0;
      if (cpu_ready_o) rdy_cnt++;
    end
    check_eq("hang_readies", 64'(rdy_cnt), 64'd0);
    check_eq("hang_cyc", {63'd0, wb_cyc_o}, 64'd1);
    check_eq("hang_err", {63'd0, bus_err_o}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
